// File: rtl/alu_ex_if.sv
// alu_ex_if: decode, ALU and writeback signals of the execute stage; slave is the stage, master is its environment
interface alu_ex_if #(
  parameter int XLEN = 32,
  parameter int REG_IDX_W = 5
);
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_op_a, in_op_b;
  logic [4:0] in_op_code;
  logic [REG_IDX_W-1:0] in_rd, in_rs_a, in_rs_b;
  logic [XLEN-1:0] alu_op_a, alu_op_b, alu_out;
  logic [4:0] alu_op_code;
  logic alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg;
  logic wb_valid, wb_ready, wb_we;
  logic [XLEN-1:0] wb_data;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [3:0] status_flags;
  modport slave (
    input in_valid, in_op_a, in_op_b, in_op_code, in_rd, in_rs_a, in_rs_b,
    output in_ready,
    output alu_op_a, alu_op_b, alu_op_code,
    input alu_out, alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg,
    output wb_valid, wb_data, wb_rd, wb_we, status_flags,
    input wb_ready
  );
  modport master (
    output in_valid, in_op_a, in_op_b, in_op_code, in_rd, in_rs_a, in_rs_b,
    input in_ready,
    input alu_op_a, alu_op_b, alu_op_code,
    output alu_out, alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg,
    input wb_valid, wb_data, wb_rd, wb_we, status_flags,
    output wb_ready
  );
endinterface

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: issue/writeback register pair around a combinational ALU; define ALU_FWD_EN for operand forwarding at accept
module alu_ex_stage #(
  parameter int XLEN = 32,
  parameter int REG_IDX_W = 5
) (
  input logic clk,
  input logic rst,
  alu_ex_if.slave bus
);
  logic s1_valid, s1_we, s2_valid, s2_we;
  logic [XLEN-1:0] s1_a, s1_b, s2_data, fwd_a, fwd_b;
  logic [4:0] s1_code;
  logic [REG_IDX_W-1:0] s1_rd, s2_rd;
  logic flag_c, flag_v, flag_p, flag_n;
  logic s2_free, s1_adv, accept, in_we;
  assign s2_free = !s2_valid || bus.wb_ready;
  assign s1_adv = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept = bus.in_valid && bus.in_ready;
  assign in_we = bus.in_op_code inside {[5'd1:5'd9], [5'd16:5'd19]};
`ifdef ALU_FWD_EN
  assign fwd_a = (bus.in_rs_a == '0) ? bus.in_op_a :
                 (s1_valid && s1_we && s1_rd == bus.in_rs_a) ? bus.alu_out :
                 (s2_valid && s2_we && s2_rd == bus.in_rs_a) ? s2_data : bus.in_op_a;
  assign fwd_b = (bus.in_rs_b == '0) ? bus.in_op_b :
                 (s1_valid && s1_we && s1_rd == bus.in_rs_b) ? bus.alu_out :
                 (s2_valid && s2_we && s2_rd == bus.in_rs_b) ? s2_data : bus.in_op_b;
`else
  logic unused_rs;
  assign unused_rs = ^{bus.in_rs_a, bus.in_rs_b};
  assign fwd_a = bus.in_op_a;
  assign fwd_b = bus.in_op_b;
`endif
  assign bus.alu_op_a = s1_a;
  assign bus.alu_op_b = s1_b;
  assign bus.alu_op_code = s1_code;
  assign bus.wb_valid = s2_valid;
  assign bus.wb_data = s2_data;
  assign bus.wb_rd = s2_rd;
  assign bus.wb_we = s2_we;
  assign bus.status_flags = {flag_c, flag_v, flag_p, flag_n};
  // Issue register: load on accept (rd cleared for non-writing ops), drop valid when the op moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_we <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_code <= '0;
      s1_rd <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_we <= in_we;
      s1_a <= fwd_a;
      s1_b <= fwd_b;
      s1_code <= bus.in_op_code;
      s1_rd <= in_we ? bus.in_rd : '0;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end
  // Writeback register: capture the ALU result on advance, hold steady under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_we <= 1'b0;
      s2_data <= '0;
      s2_rd <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_we <= s1_we;
      s2_data <= bus.alu_out;
      s2_rd <= s1_rd;
    end else if (bus.wb_ready) begin
      s2_valid <= 1'b0;
    end
  end
  // Architectural flags: writing ops update neg/parity/overflow, only ADD/SUB touch carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {flag_c, flag_v, flag_p, flag_n} <= '0;
    end else if (s1_adv && s1_we) begin
      flag_v <= bus.alu_flag_overflow;
      flag_p <= bus.alu_flag_parity;
      flag_n <= bus.alu_flag_neg;
      flag_c <= (s1_code == 5'd16 || s1_code == 5'd17) ? bus.alu_flag_carry : flag_c;
    end
  end
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed vectors for alu_ex_stage with a scoreboard queue checked by an independent writeback monitor
module tb_alu_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [31:0] d;
    logic [4:0] rd;
    logic we;
  } exp_t;
  exp_t sb[$];
  alu_ex_if #(.XLEN(32), .REG_IDX_W(5)) bus ();
  alu_ex_stage #(.XLEN(32), .REG_IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  logic [32:0] sum, dif;
  logic [31:0] res;
  logic [4:0] code;
  always_comb begin
    code = bus.alu_op_code;
    sum = {1'b0, bus.alu_op_a} + {1'b0, bus.alu_op_b};
    dif = {1'b0, bus.alu_op_a} - {1'b0, bus.alu_op_b};
    res = (code == 5'd1) ? (bus.alu_op_a & bus.alu_op_b) :
          (code == 5'd2) ? (bus.alu_op_a | bus.alu_op_b) :
          (code == 5'd3) ? (bus.alu_op_a ^ bus.alu_op_b) :
          (code == 5'd16) ? sum[31:0] :
          (code == 5'd17) ? dif[31:0] : 32'd0;
  end
  assign bus.alu_out = res;
  assign bus.alu_flag_carry = (code == 5'd16) ? sum[32] : (code == 5'd17) ? dif[32] : 1'b0;
  assign bus.alu_flag_overflow = (code == 5'd16) ? (bus.alu_op_a[31] == bus.alu_op_b[31] && res[31] != bus.alu_op_a[31]) :
                                 (code == 5'd17) ? (bus.alu_op_a[31] != bus.alu_op_b[31] && res[31] != bus.alu_op_a[31]) : 1'b0;
  assign bus.alu_flag_parity = ^res;
  assign bus.alu_flag_neg = res[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [4:0] rs_a, input logic [31:0] exp_d, input logic [4:0] exp_rd, input logic exp_we);
    bus.in_valid = 1'b1;
    bus.in_op_code = op;
    bus.in_op_a = a;
    bus.in_op_b = b;
    bus.in_rd = rd;
    bus.in_rs_a = rs_a;
    bus.in_rs_b = 5'd0;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        sb.push_back('{d: exp_d, rd: exp_rd, we: exp_we});
        cyc();
        bus.in_valid = 1'b0;
        return;
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.wb_valid && bus.wb_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got data %h rd %0d with nothing expected", bus.wb_data, bus.wb_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_data", bus.wb_data, e.d);
          chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
          chk("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op_a = '0;
    bus.in_op_b = '0;
    bus.in_op_code = '0;
    bus.in_rd = '0;
    bus.in_rs_a = '0;
    bus.in_rs_b = '0;
    bus.wb_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd_we", {26'd0, bus.wb_rd, bus.wb_we}, 32'd0);
    chk("rst_flags", {28'd0, bus.status_flags}, 32'd0);
    chk("rst_alu_a", bus.alu_op_a, 32'd0);
    chk("rst_alu_code", {27'd0, bus.alu_op_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    issue(5'd16, 32'hFFFFFFFF, 32'h1, 5'd3, 5'd0, 32'h0, 5'd3, 1'b1);
    chk("lat_early", {31'd0, bus.wb_valid}, 32'd0);
    cyc();
    chk("lat_exact", {31'd0, bus.wb_valid}, 32'd1);
    chk("add_flags", {28'd0, bus.status_flags}, 32'h8);
    wait_empty();

    chk("b2b_ready0", {31'd0, bus.in_ready}, 32'd1);
    issue(5'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd1, 5'd0, 32'h00F000F0, 5'd1, 1'b1);
    chk("b2b_ready1", {31'd0, bus.in_ready}, 32'd1);
    issue(5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 5'd0, 32'hFFF0FFF0, 5'd2, 1'b1);
    chk("b2b_ready2", {31'd0, bus.in_ready}, 32'd1);
    issue(5'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 5'd0, 32'hFF00FF00, 5'd3, 1'b1);
    chk("b2b_pipe", {31'd0, bus.wb_valid}, 32'd1);
    wait_empty();
    chk("logic_flags", {28'd0, bus.status_flags}, 32'h9);

    bus.wb_ready = 1'b0;
    issue(5'd16, 32'd5, 32'd7, 5'd1, 5'd0, 32'd12, 5'd1, 1'b1);
    issue(5'd17, 32'd10, 32'd3, 5'd2, 5'd0, 32'd7, 5'd2, 1'b1);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    repeat (3) cyc();
    chk("bp_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_data_stable", bus.wb_data, 32'd12);
    chk("bp_rd_stable", {27'd0, bus.wb_rd}, 32'd1);
    bus.wb_ready = 1'b1;
    wait_empty();
    chk("bp_flags", {28'd0, bus.status_flags}, 32'h2);

    issue(5'd17, 32'd3, 32'd10, 5'd4, 5'd0, 32'hFFFFFFF9, 5'd4, 1'b1);
    wait_empty();
    chk("sub_flags", {28'd0, bus.status_flags}, 32'h9);
    issue(5'd1, 32'hFF, 32'h0F, 5'd5, 5'd0, 32'h0F, 5'd5, 1'b1);
    wait_empty();
    chk("and_keeps_carry", {28'd0, bus.status_flags}, 32'h8);
    issue(5'd0, 32'd5, 32'd5, 5'd7, 5'd0, 32'd0, 5'd0, 1'b0);
    issue(5'd12, 32'd1, 32'd2, 5'd9, 5'd0, 32'd0, 5'd0, 1'b0);
    wait_empty();
    chk("nop_flags", {28'd0, bus.status_flags}, 32'h8);

    bus.wb_ready = 1'b0;
    issue(5'd16, 32'd1, 32'd1, 5'd1, 5'd0, 32'd2, 5'd1, 1'b1);
    issue(5'd16, 32'd2, 32'd2, 5'd2, 5'd0, 32'd4, 5'd2, 1'b1);
    chk("pre_rst_valid", {31'd0, bus.wb_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("async_rst_flags", {28'd0, bus.status_flags}, 32'd0);
    chk("async_rst_code", {27'd0, bus.alu_op_code}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.wb_ready = 1'b1;
    repeat (3) cyc();
    chk("rel_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    issue(5'd16, 32'd2, 32'd3, 5'd3, 5'd0, 32'd5, 5'd3, 1'b1);
    wait_empty();

    issue(5'd16, 32'd2, 32'd3, 5'd5, 5'd0, 32'd5, 5'd5, 1'b1);
`ifdef ALU_FWD_EN
    issue(5'd16, 32'd0, 32'd1, 5'd6, 5'd5, 32'd6, 5'd6, 1'b1);
`else
    issue(5'd16, 32'd0, 32'd1, 5'd6, 5'd5, 32'd1, 5'd6, 1'b1);
`endif
    wait_empty();

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
